// File: rtl/wb_demo_if.sv
// Wishbone classic bus bundle for the wb_demo_core co-processor.
interface wb_demo_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [4:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_demo_core.sv
// wb_demo_core: memory-mapped arithmetic/logic co-processor on a Wishbone
// classic slave port. Software loads OPA/OPB, writes CMD, polls STATUS.DONE
// and reads RESULT.
//
// state | meaning
// IDLE  | waiting for an accepted CMD write
// EXEC  | single-cycle ALU op, RESULT/DONE land on the next edge
// MUL   | shift-add multiply, one multiplier bit per cycle for 32 cycles
module wb_demo_core (
  input  logic     wb_clk_i,
  input  logic     wb_rst_i,
  wb_demo_if.slave wb
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;

  localparam logic [2:0] REG_OPA  = 3'd0;
  localparam logic [2:0] REG_OPB  = 3'd1;
  localparam logic [2:0] REG_CMD  = 3'd2;
  localparam logic [2:0] REG_RES  = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic [1:0]  state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] res_q, res_d;
  logic        done_q, done_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        req;
  logic        wr;
  logic        busy;
  logic        cmd_go;
  logic [2:0]  reg_sel;
  logic [31:0] rdata;
  logic [31:0] exec_res;
  logic [31:0] acc_nxt;
  logic        unused_adr;

  // A new request is only taken when no ack is outstanding, which gives the
  // single wait state and keeps acks from landing on consecutive cycles.
  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr      = req & wb.wb_we_i;
  assign reg_sel = wb.wb_adr_i[4:2];
  assign busy    = (state_q != ST_IDLE);
  assign cmd_go  = wr & (reg_sel == REG_CMD) & wb.wb_sel_i[0] & ~busy;
  assign acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;

  assign unused_adr = ^wb.wb_adr_i[1:0];

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Register read mux, sampled into dat_q on the strobe-sampling edge.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_OPA:  rdata = opa_q;
      REG_OPB:  rdata = opb_q;
      REG_CMD:  rdata = {29'd0, cmd_q};
      REG_RES:  rdata = res_q;
      REG_STAT: rdata = {30'd0, busy, done_q};
      default:  rdata = '0;
    endcase
  end

  // Single-cycle ALU on the operands latched at command acceptance.
  always_comb begin
    exec_res = '0;
    case (cmd_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_SHL:  exec_res = a_q << b_q[4:0];
      OP_SHR:  exec_res = a_q >> b_q[4:0];
      default: exec_res = '0;
    endcase
  end

  // Bus handshake, register writes and the operation sequencer.
  always_comb begin
    state_d = state_q;
    ack_d   = req;
    dat_d   = (req & ~wb.wb_we_i) ? rdata : 32'd0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cmd_d   = cmd_q;
    res_d   = res_q;
    done_d  = done_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    if (wr && reg_sel == REG_OPA) opa_d = merge_bytes(opa_q, wb.wb_dat_i, wb.wb_sel_i);
    if (wr && reg_sel == REG_OPB) opb_d = merge_bytes(opb_q, wb.wb_dat_i, wb.wb_sel_i);

    case (state_q)
      ST_IDLE: begin
        if (cmd_go) begin
          cmd_d   = wb.wb_dat_i[2:0];
          a_d     = opa_q;
          b_d     = opb_q;
          acc_d   = '0;
          cnt_d   = 5'd31;
          done_d  = 1'b0;
          state_d = (wb.wb_dat_i[2:0] == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = exec_res;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_MUL: begin
        acc_d = acc_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        if (cnt_q == 5'd0) begin
          res_d   = acc_nxt;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any running operation.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_demo_core.sv
// Testbench for wb_demo_core: directed scenarios plus randomized operations
// checked against a register-level reference model.
module tb_wb_demo_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_demo_if bus();

  wb_demo_core dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb       (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model: register contents plus the edge number at which the
  // last command was accepted; status/result follow from the latencies.
  logic [31:0] m_opa, m_opb, m_old, m_new;
  logic [2:0]  m_cmd;
  bit          m_started, m_mul;
  int          m_c0;

  task automatic model_reset();
    m_opa = '0; m_opb = '0; m_old = '0; m_new = '0;
    m_cmd = '0; m_started = 0; m_mul = 0; m_c0 = 0;
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return r;
  endfunction

  // e = edge number at which the access is sampled; it sees the state left by edge e-1.
  function automatic bit m_busy(input int e);
    return m_started && ((e - m_c0) <= (m_mul ? 32 : 1));
  endfunction

  function automatic bit m_done(input int e);
    return m_started && ((e - m_c0) >= (m_mul ? 33 : 2));
  endfunction

  function automatic logic [31:0] m_result(input int e);
    return m_done(e) ? m_new : m_old;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] adr, input int e);
    case (adr[4:2])
      3'd0: return m_opa;
      3'd1: return m_opb;
      3'd2: return {29'd0, m_cmd};
      3'd3: return m_result(e);
      3'd4: return {30'd0, m_busy(e), m_done(e)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [4:0] adr, input logic [3:0] sel, input logic [31:0] dat, input int e);
    case (adr[4:2])
      3'd0: m_opa = merge(m_opa, dat, sel);
      3'd1: m_opb = merge(m_opb, dat, sel);
      3'd2: if (sel[0] && !m_busy(e)) begin
        m_old     = m_result(e);
        m_new     = ref_op(dat[2:0], m_opa, m_opb);
        m_cmd     = dat[2:0];
        m_mul     = (dat[2:0] == 3'd2);
        m_c0      = e;
        m_started = 1;
      end
      default: ;
    endcase
  endtask

  // One bus transfer; e returns the edge that raised ack (-1 on timeout).
  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rd, output int e);
    int n;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_sel_i = sel;  bus.wb_dat_i = dat;
    n = 0; e = -1; rd = '0;
    while (e < 0 && n < 8) begin
      @(posedge clk); #1; n++;
      if (bus.wb_ack_o === 1'b1) begin rd = bus.wb_dat_o; e = cyc_n; end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    if (e < 0) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout: adr=%h we=%b got no ack, required ack within 8 cycles", adr, we);
    end else if (we) begin
      model_write(adr, sel, dat, e);
    end
  endtask

  task automatic wait_done(output bit ok);
    logic [31:0] rd; int e;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      wb_xfer(1'b0, 5'h10, 4'hF, 32'd0, rd, e);
      if (rd[0] === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; int e;
    rst_n = 1'b0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_sel_i = 4'hF; bus.wb_dat_i = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'd0) begin
        n_err++;
        $display("FAIL reset_ack[%0d]: ack=%b dat=%h, required ack=0 dat=0", i, bus.wb_ack_o, bus.wb_dat_o);
      end
    end
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int r = 0; r < 8; r++) begin
      wb_xfer(1'b0, 5'(r * 4), 4'hF, 32'd0, rd, e);
      n_cmp++;
      if (rd !== 32'd0) begin
        n_err++; $display("FAIL reset_read[%0d]: got %h, required 00000000", r, rd);
      end
    end
  endtask

  task automatic test_add();
    logic [31:0] rd; int e; bit done;
    wb_xfer(1'b1, 5'h00, 4'hF, 32'h1234, rd, e);
    wb_xfer(1'b1, 5'h04, 4'hF, 32'h1235, rd, e);
    wb_xfer(1'b1, 5'h08, 4'hF, 32'h0, rd, e);
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      wb_xfer(1'b0, 5'h10, 4'hF, 32'd0, rd, e);
      n_cmp++;
      if (rd !== model_read(5'h10, e)) begin
        n_err++; $display("FAIL add_status: got %h, required %h", rd, model_read(5'h10, e));
      end
      done = (rd[0] === 1'b1);
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL add_poll: DONE not seen, required DONE=1"); end
    wb_xfer(1'b0, 5'h0C, 4'hF, 32'd0, rd, e);
    n_cmp++;
    if (rd !== 32'h00002469) begin n_err++; $display("FAIL add_result: got %h, required 00002469", rd); end
  endtask

  task automatic test_mul();
    logic [31:0] rd; int e; bit done; int busy_seen;
    wb_xfer(1'b1, 5'h08, 4'hF, 32'h2, rd, e);
    done = 0; busy_seen = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      wb_xfer(1'b0, 5'h10, 4'hF, 32'd0, rd, e);
      n_cmp++;
      if (rd !== model_read(5'h10, e)) begin
        n_err++; $display("FAIL mul_status: got %h, required %h at %0d cycles", rd, model_read(5'h10, e), e - m_c0);
      end
      if (rd[1] === 1'b1) busy_seen++;
      done = (rd[0] === 1'b1);
    end
    n_cmp++;
    if (!done || busy_seen < 10) begin
      n_err++; $display("FAIL mul_poll: done=%b busy_polls=%0d, required done=1 busy_polls>=10", done, busy_seen);
    end
    wb_xfer(1'b0, 5'h0C, 4'hF, 32'd0, rd, e);
    n_cmp++;
    if (rd !== 32'h014B6CC4) begin n_err++; $display("FAIL mul_result: got %h, required 014B6CC4", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] ta [3] = '{32'h0, 32'hFFFFFFFF, 32'h1};
    logic [31:0] tb [3] = '{32'h1, 32'h2, 32'd31};
    logic [2:0]  top[3] = '{3'd1, 3'd0, 3'd6};
    logic [31:0] tx [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000};
    logic [31:0] rd; int e; bit ok;
    for (int i = 0; i < 3; i++) begin
      wb_xfer(1'b1, 5'h00, 4'hF, ta[i], rd, e);
      wb_xfer(1'b1, 5'h04, 4'hF, tb[i], rd, e);
      wb_xfer(1'b1, 5'h08, 4'hF, {29'd0, top[i]}, rd, e);
      wait_done(ok);
      wb_xfer(1'b0, 5'h0C, 4'hF, 32'd0, rd, e);
      n_cmp++;
      if (!ok || rd !== tx[i]) begin
        n_err++; $display("FAIL wrap[%0d]: done=%b result=%h, required done=1 result=%h", i, ok, rd, tx[i]);
      end
    end
  endtask

  task automatic test_byte_en();
    logic [31:0] rd; int e;
    logic [4:0] adrs [5] = '{5'h0C, 5'h10, 5'h08, 5'h14, 5'h1C};
    wb_xfer(1'b1, 5'h00, 4'hF, 32'h11223344, rd, e);
    wb_xfer(1'b1, 5'h00, 4'b0101, 32'hAABBCCDD, rd, e);
    wb_xfer(1'b0, 5'h00, 4'h0, 32'd0, rd, e);
    n_cmp++;
    if (rd !== 32'h11BB33DD) begin n_err++; $display("FAIL byte_en: got %h, required 11BB33DD", rd); end
    // RO registers, CMD without sel[0] and unmapped space must ignore writes.
    wb_xfer(1'b1, 5'h0C, 4'hF, 32'hFFFFFFFF, rd, e);
    wb_xfer(1'b1, 5'h10, 4'hF, 32'hFFFFFFFF, rd, e);
    wb_xfer(1'b1, 5'h08, 4'b1110, 32'h5, rd, e);
    wb_xfer(1'b1, 5'h14, 4'hF, 32'hFFFFFFFF, rd, e);
    wb_xfer(1'b1, 5'h1C, 4'hF, 32'hFFFFFFFF, rd, e);
    for (int i = 0; i < 5; i++) begin
      wb_xfer(1'b0, adrs[i], 4'hF, 32'd0, rd, e);
      n_cmp++;
      if (rd !== model_read(adrs[i], e)) begin
        n_err++; $display("FAIL ro_write[%h]: got %h, required %h", adrs[i], rd, model_read(adrs[i], e));
      end
    end
  endtask

  task automatic test_busy();
    logic [31:0] rd; int e; bit ok;
    wb_xfer(1'b1, 5'h00, 4'hF, 32'h1234, rd, e);
    wb_xfer(1'b1, 5'h04, 4'hF, 32'h1235, rd, e);
    wb_xfer(1'b1, 5'h08, 4'hF, 32'h2, rd, e);
    wb_xfer(1'b1, 5'h08, 4'hF, 32'h0, rd, e);
    wb_xfer(1'b1, 5'h00, 4'hF, 32'h5, rd, e);
    wb_xfer(1'b0, 5'h00, 4'hF, 32'd0, rd, e);
    n_cmp++;
    if (rd !== 32'h5) begin n_err++; $display("FAIL busy_opa: got %h, required 00000005", rd); end
    wb_xfer(1'b0, 5'h08, 4'hF, 32'd0, rd, e);
    n_cmp++;
    if (rd !== 32'h2) begin n_err++; $display("FAIL busy_cmd: got %h, required 00000002", rd); end
    wait_done(ok);
    wb_xfer(1'b0, 5'h0C, 4'hF, 32'd0, rd, e);
    n_cmp++;
    if (!ok || rd !== 32'h014B6CC4) begin
      n_err++; $display("FAIL busy_result: done=%b result=%h, required done=1 result=014B6CC4", ok, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic prev_ack;
    int acks;
    @(negedge clk);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 5'h00; bus.wb_sel_i = 4'hF;
    prev_ack = 1'b0; acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.wb_ack_o !== ((i % 2) == 0) ||
          bus.wb_dat_o !== (bus.wb_ack_o ? m_opa : 32'd0) ||
          (prev_ack && bus.wb_ack_o)) begin
        n_err++;
        $display("FAIL b2b[%0d]: ack=%b dat=%h, required ack=%b dat=%h", i, bus.wb_ack_o,
                 bus.wb_dat_o, ((i % 2) == 0), (((i % 2) == 0) ? m_opa : 32'd0));
      end
      if (bus.wb_ack_o === 1'b1) acks++;
      prev_ack = bus.wb_ack_o;
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    n_cmp++;
    if (acks != 3) begin n_err++; $display("FAIL b2b_count: got %0d acks, required 3", acks); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, b, cd; logic [3:0] s; logic [2:0] op; int e; bit done;
    for (int t = 0; t < 30; t++) begin
      a = $urandom; b = $urandom; op = 3'($urandom_range(7, 0));
      s = 4'($urandom_range(15, 0));
      if (t % 4 == 0) b = 32'($urandom_range(31, 0));
      wb_xfer(1'b1, 5'h00, s, a, rd, e);
      wb_xfer(1'b1, 5'h04, 4'hF, b, rd, e);
      cd = {29'($urandom), op};
      wb_xfer(1'b1, 5'h08, 4'($urandom | 1), cd, rd, e);
      done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
        wb_xfer(1'b0, 5'h10, 4'($urandom), 32'd0, rd, e);
        n_cmp++;
        if (rd !== model_read(5'h10, e)) begin
          n_err++; $display("FAIL rnd_status[%0d]: got %h, required %h", t, rd, model_read(5'h10, e));
        end
        done = (rd[0] === 1'b1);
      end
      wb_xfer(1'b0, 5'h0C, 4'hF, 32'd0, rd, e);
      n_cmp++;
      if (!done || rd !== model_read(5'h0C, e)) begin
        n_err++; $display("FAIL rnd_result[%0d]: op=%0d done=%b got %h, required %h", t, op, done, rd, model_read(5'h0C, e));
      end
      wb_xfer(1'b0, 5'h00, 4'hF, 32'd0, rd, e);
      n_cmp++;
      if (rd !== m_opa) begin n_err++; $display("FAIL rnd_opa[%0d]: got %h, required %h", t, rd, m_opa); end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] rd; int e;
    logic [4:0] adrs [4] = '{5'h10, 5'h0C, 5'h00, 5'h08};
    wb_xfer(1'b1, 5'h00, 4'hF, 32'h0000BEEF, rd, e);
    wb_xfer(1'b1, 5'h08, 4'hF, 32'h2, rd, e);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, adrs[i], 4'hF, 32'd0, rd, e);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL rst_mul[%h]: got %h, required 00000000", adrs[i], rd); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion before 2 ms");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_add();
    test_mul();
    test_wrap();
    test_byte_en();
    test_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_demo_core.md
# wb_demo_core

Wishbone B3 classic 32-bit slave holding two operand registers, a command register, a result register and a status register. Writing the command register starts an arithmetic/logic operation on the operands; software polls the status "done" bit and then reads the result. It sits on a peripheral Wishbone bus behind a single bus master. It is a small memory-mapped co-processor.

## Interface
- No parameters; data width fixed at 32, address width at 5.
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe; transfer requested when wb_cyc_i & wb_stb_i.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  5  byte address; bits [4:2] select register, [1:0] ignored.
- wb_sel_i  in  4  byte enables; sel[n] qualifies dat[8n+7:8n] on writes.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o = 1, else 0.
- wb_ack_o  out  1  transfer acknowledge.

## Operation
- Register map:
  - 0x00 OPA: R/W.
  - 0x04 OPB: R/W.
  - 0x08 CMD: R/W, bits [2:0] opcode, upper bits read 0.
  - 0x0C RESULT: RO.
  - 0x10 STATUS: RO, bit0 DONE, bit1 BUSY, others 0.
  - 0x14–0x1C: read 0, writes ignored.
- Writes to OPA/OPB are byte-masked by wb_sel_i.
- Writes to RESULT/STATUS are ignored.
- CMD write with sel[0] = 1 and BUSY = 0:
  - stores the opcode;
  - latches OPA/OPB into internal operand registers;
  - clears DONE, sets BUSY.
- CMD write while BUSY = 1 is ignored entirely.
- Opcodes; all results 32-bit, wrap modulo 2^32, no flags:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 MUL: low 32 bits of A*B, iterative shift-add, one bit per cycle.
  - 3 AND; 4 OR; 5 XOR.
  - 6 SHL: A << B[4:0].
  - 7 SHR: logical A >> B[4:0].
- On completion: RESULT updated, DONE = 1, BUSY = 0.
- DONE stays 1 until the next accepted CMD write or reset.
- OPA/OPB may be rewritten during BUSY without affecting the running operation.
- FSM states:
  - IDLE → (accepted CMD, opcode ≠ 2) → EXEC → IDLE.
  - IDLE → (accepted CMD, opcode = 2) → MUL, 32 iterations → IDLE.
- Reset mid-operation aborts it; all state returns to reset values.

## Timing
- Reset values: wb_ack_o = 0, wb_dat_o = 0, and OPA, OPB, CMD, RESULT, STATUS all 0 (DONE = 0, BUSY = 0).
- Acknowledge is registered:
  - wb_ack_o = 1 for exactly one cycle, on the edge after wb_cyc_i & wb_stb_i is sampled with wb_ack_o = 0.
  - Every access has one wait state.
  - Back-to-back strobes never produce two consecutive ack cycles.
- Write data is committed on the same edge that raises wb_ack_o.
- Read data is registered alongside ack and reflects register contents at the strobe-sampling edge.
- If wb_cyc_i or wb_stb_i drops before ack, no access occurs and no ack is issued.
- Latency counts from the edge that commits the CMD write (cycle 0):
  - EXEC ops: RESULT and DONE = 1 at cycle 1, so a STATUS read started after the CMD ack sees DONE = 1.
  - MUL: DONE = 1 at cycle 32; BUSY reads 1 in cycles 0–31.
- wb_sel_i is ignored on reads; the full 32 bits are returned.

## Test plan
- Reset: assert wb_rst_i low for 5 cycles, release, read 0x00–0x1C → all 0; wb_ack_o stays 0 during reset.
- ADD: write 0x00 = 0x1234, 0x04 = 0x1235, 0x08 = 0; poll 0x10 until bit0 = 1; read 0x0C → 0x00002469.
- MUL: same operands, 0x08 = 2; BUSY observed = 1 on polls; DONE reached after ≥ 32 cycles; read 0x0C → 0x014B6CC4.
- Wrap, SUB, shift:
  - SUB with A = 0, B = 1 → 0xFFFFFFFF.
  - ADD with 0xFFFFFFFF + 2 → 0x00000001.
  - SHL 1 << 31 → 0x80000000.
- Byte enables:
  - Write 0x00 = 0xAABBCCDD with sel = 0b0101 over prior 0x11223344 → read 0x11BB33DD.
  - Write to 0x0C/0x10 has no effect.
- Busy protection:
  - During MUL, write CMD = 0 and OPA = 5 → CMD write ignored, MUL result unchanged, OPA reads 5.
  - Reset mid-MUL → STATUS = 0, RESULT = 0.
